dcache_assoc: RTL
=================

// Module: dcache_assoc
// PURPOSE
//   Parametrised N-way set-associative, write-back, write-allocate L1 data cache. Sits between the pipeline
//   memory stage and the AXI/ACE data master port; drop-in successor to the direct-mapped dcache.
//   Adds: configurable ways/size/line length, per-set round-robin victim selection, B-channel completion
//   wait before refill, and snoop invalidation across all ways.
// PARAMETERS
//   ID_WIDTH    13     AXI id width
//   ADDR_WIDTH  64     address width
//   DATA_WIDTH  64     AXI/pipeline data width; word = DATA_WIDTH/8 bytes
//   SIZE_BYTES  16384  total data capacity
//   WAYS        2      associativity, power of 2, 1..8
//   LINE_WORDS  8      words per line, power of 2, 2..16; SETS = SIZE_BYTES/(WAYS*LINE_WORDS*word bytes)
// PORTS
//   clk            in   1      clock, all flops rise-edge
//   reset          in   1      asynchronous active-high reset
//   addr           in   64     pipeline byte address
//   wdata          in   64     store data, right-aligned
//   wlen           in   2      store size = 2^wlen bytes, naturally aligned
//   dcache_enable  in   1      request valid, held until hit/done
//   wrn            in   1      1 = store, 0 = load
//   rdata          out  64     full hit word (pipeline extracts bytes)
//   dcache_valid   out  1      load hit this cycle
//   write_done     out  1      store accepted this cycle
//   m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}/awready     write-address channel
//   m_axi_w{data,strb,last,valid}/wready                               write-data channel
//   m_axi_b{id,resp,valid}/bready                                      write-response channel
//   m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}/arready     read-address channel
//   m_axi_r{id,data,resp,last,valid}/rready                            read-data channel
//   m_axi_ac{valid,addr,snoop}/acready                                 snoop channel
// BEHAVIOUR
//   Reset (async): state=IDLE; all valid/dirty/rr pointers 0; aw/w/ar/r valid/ready=0; acready=1; bready=0.
//   Constant attributes: ar/aw id=1, len=LINE_WORDS-1, size=log2(word bytes), lock=0, cache=0, prot=3'h6;
//   arburst=WRAP, awburst=INCR, wstrb all ones.
//   Lookup is combinational: hit = valid & tag match in any way; at most one way may match (checked by assertion).
//   dcache_valid = IDLE & enable & !wrn & hit & !acvalid; rdata = hit way's word, same cycle.
//   write_done = IDLE & enable & wrn & hit & !acvalid; byte lanes written and dirty set at that edge.
//   Miss in IDLE: latch addr; victim = lowest-index invalid way, else rr[set];
//   victim valid&dirty -> WB_ADDR, else FILL_ADDR.
//   WB_ADDR: awvalid=1, awaddr=victim line base; awready -> WB_DATA, offset=0.
//   WB_DATA: wvalid=1, words 0..LINE_WORDS-1, wlast on final word; handshake on wlast -> WB_RESP.
//   WB_RESP: bready=1; bvalid -> clear victim dirty, FILL_ADDR. bresp!=OKAY is ignored (no retry).
//   FILL_ADDR: victim valid=0, tag<=new tag; arvalid=1, araddr=word-aligned miss addr
//   (critical word first, wrap); arready -> FILL_DATA.
//   FILL_DATA: rready=1; each rvalid writes word at offset and offset wraps mod LINE_WORDS.
//   rlast -> valid=1, rr[set]<=rr[set]+1 (mod WAYS), IDLE. Request is retried by lookup next cycle.
//   Snoop: acready only in IDLE. acvalid & acsnoop==4'hd invalidates matching way (valid=0, dirty=0, no writeback).
//   Snoop has priority over a same-cycle pipeline request: no hit/done asserted that cycle.
//   Other snoop codes are accepted with no effect.
//   Line tag/valid are stable across the burst; a store never hits a line in FILL_* (valid=0).
//   Reset mid-burst: FSM returns to IDLE immediately; cache contents invalidated.
//   Pipeline must not drop a request during a miss; addr change while busy is undefined.
// TESTING
//   1. Load 0x1000 cold -> ar addr 0x1000, arburst=2, arlen=7; after 8 beats, next cycle dcache_valid=1 with beat-0 data.
//   2. Two loads, same set, different tags (WAYS=2) -> both resident; re-load both -> hit, no AR.
//   3. Store byte 0xAB @0x1003 hit, then evict via 2 conflicting fills -> aw addr 0x1000, 8 W beats, beat0 byte3=0xAB;
//      AR issued only after bvalid.
//   4. Miss at 0x1028 -> araddr 0x1028; rdata beats land at words 5,6,7,0..4; wlast/rlast one per burst.
//   5. acvalid, acsnoop=4'hd, addr 0x1000 with concurrent hit request -> no dcache_valid that cycle;
//      next load to 0x1000 misses.
//   6. Assert reset during WB_DATA beat 3 -> all valids 0 asynchronously, FSM IDLE, wvalid=0 before next edge.

Source files
------------

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back/write-allocate L1 data cache with an AXI/ACE master.
// Combinational lookup, round-robin victim per set, critical-word-first wrapping refill.
module dcache_assoc #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SIZE_BYTES = 16384,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [1:0]              wlen,
  input  logic                    dcache_enable,
  input  logic                    wrn,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    dcache_valid,
  output logic                    write_done,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    m_axi_acvalid,
  input  logic [ADDR_WIDTH-1:0]   m_axi_acaddr,
  input  logic [3:0]              m_axi_acsnoop,
  output logic                    m_axi_acready
);
  localparam int WB    = DATA_WIDTH / 8;
  localparam int BB    = $clog2(WB);
  localparam int OB    = $clog2(LINE_WORDS);
  localparam int SETS  = SIZE_BYTES / (WAYS * LINE_WORDS * WB);
  localparam int IB    = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IB - OB - BB;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, WB_ADDR, WB_DATA, WB_RESP, FILL_ADDR, FILL_DATA} state_t;

  state_t                       state_q;
  logic [DATA_WIDTH-1:0]        data_q [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]             tag_q  [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0]    valid_q, dirty_q;
  logic [SETS-1:0][WW-1:0]      rr_q;
  logic [ADDR_WIDTH-1:0]        maddr_q, awaddr_q;
  logic [WW-1:0]                vic_q;
  logic [OB-1:0]                off_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, acready_q;

  assign m_axi_awid    = ID_WIDTH'(1);
  assign m_axi_arid    = ID_WIDTH'(1);
  assign m_axi_awlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_awsize  = 3'(BB);
  assign m_axi_arsize  = 3'(BB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b10;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_awcache = 4'h0;
  assign m_axi_arcache = 4'h0;
  assign m_axi_awprot  = 3'h6;
  assign m_axi_arprot  = 3'h6;
  assign m_axi_wstrb   = '1;

  wire [TAG_W-1:0] req_tag = addr[ADDR_WIDTH-1 -: TAG_W];
  wire [IB-1:0]    req_idx = addr[BB+OB +: IB];
  wire [OB-1:0]    req_off = addr[BB +: OB];
  wire [BB-1:0]    boff    = addr[BB-1:0];
  wire [TAG_W-1:0] m_tag   = maddr_q[ADDR_WIDTH-1 -: TAG_W];
  wire [IB-1:0]    m_idx   = maddr_q[BB+OB +: IB];
  wire [OB-1:0]    m_off   = maddr_q[BB +: OB];
  wire [TAG_W-1:0] ac_tag  = m_axi_acaddr[ADDR_WIDTH-1 -: TAG_W];
  wire [IB-1:0]    ac_idx  = m_axi_acaddr[BB+OB +: IB];

  logic [WAYS-1:0] hit_vec, ac_vec;
  logic [WW-1:0]   hit_way, vic_d;
  always_comb begin
    hit_way = '0;
    vic_d   = rr_q[req_idx];
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
      ac_vec[w]  = valid_q[w][ac_idx] && (tag_q[w][ac_idx] == ac_tag);
      if (hit_vec[w]) hit_way = WW'(w);
    end
    // descending scan so the lowest-index invalid way wins
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w][req_idx]) vic_d = WW'(w);
  end

  wire hit       = |hit_vec;
  wire idle      = (state_q == IDLE);
  wire req_ok    = idle && dcache_enable && !m_axi_acvalid;
  wire miss      = req_ok && !hit;
  wire snoop_inv = idle && acready_q && m_axi_acvalid && (m_axi_acsnoop == 4'hd);
  wire vic_dirty = valid_q[vic_d][req_idx] && dirty_q[vic_d][req_idx];

  assign dcache_valid  = req_ok && !wrn && hit;
  assign write_done    = req_ok && wrn && hit;
  assign rdata         = data_q[hit_way][req_idx][req_off];
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = data_q[vic_q][m_idx][off_q];
  assign m_axi_wlast   = wvalid_q && (off_q == OB'(LINE_WORDS - 1));
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = {maddr_q[ADDR_WIDTH-1:BB], {BB{1'b0}}};
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_acready = acready_q;

  logic [WB-1:0]         bmask;
  logic [DATA_WIDTH-1:0] sdata;
  always_comb begin
    bmask = WB'(((1 << (1 << wlen)) - 1) << boff);
    sdata = wdata << {boff, 3'b000};
  end

  // Data and tags are not reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (write_done)
      for (int b = 0; b < WB; b++)
        if (bmask[b]) data_q[hit_way][req_idx][req_off][b*8 +: 8] <= sdata[b*8 +: 8];
    if (state_q == FILL_DATA && m_axi_rvalid)
      data_q[vic_q][m_idx][off_q] <= m_axi_rdata;
    if (state_q == FILL_ADDR)
      tag_q[vic_q][m_idx] <= m_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      rr_q      <= '0;
      maddr_q   <= '0;
      awaddr_q  <= '0;
      vic_q     <= '0;
      off_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      acready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (snoop_inv) begin
            for (int w = 0; w < WAYS; w++)
              if (ac_vec[w]) begin
                valid_q[w][ac_idx] <= 1'b0;
                dirty_q[w][ac_idx] <= 1'b0;
              end
          end else if (write_done) begin
            dirty_q[hit_way][req_idx] <= 1'b1;
          end else if (miss) begin
            maddr_q   <= addr;
            vic_q     <= vic_d;
            acready_q <= 1'b0;
            if (vic_dirty) begin
              awaddr_q  <= {tag_q[vic_d][req_idx], req_idx, {(OB+BB){1'b0}}};
              awvalid_q <= 1'b1;
              state_q   <= WB_ADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= FILL_ADDR;
            end
          end
        end
        WB_ADDR: if (m_axi_awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          off_q     <= '0;
          state_q   <= WB_DATA;
        end
        WB_DATA: if (m_axi_wready) begin
          off_q <= off_q + 1'b1;
          if (m_axi_wlast) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= WB_RESP;
          end
        end
        WB_RESP: if (m_axi_bvalid) begin
          bready_q              <= 1'b0;
          dirty_q[vic_q][m_idx] <= 1'b0;
          arvalid_q             <= 1'b1;
          state_q               <= FILL_ADDR;
        end
        FILL_ADDR: begin
          valid_q[vic_q][m_idx] <= 1'b0;
          dirty_q[vic_q][m_idx] <= 1'b0;
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            off_q     <= m_off;
            state_q   <= FILL_DATA;
          end
        end
        FILL_DATA: if (m_axi_rvalid) begin
          off_q <= off_q + 1'b1;
          if (m_axi_rlast) begin
            rready_q              <= 1'b0;
            valid_q[vic_q][m_idx] <= 1'b1;
            rr_q[m_idx]           <= (rr_q[m_idx] == WW'(WAYS - 1)) ? '0 : rr_q[m_idx] + 1'b1;
            acready_q             <= 1'b1;
            state_q               <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_one_hit: assert property (@(posedge clk) disable iff (reset) $onehot0(hit_vec));

  wire unused_ok = ^{m_axi_bid, m_axi_bresp, m_axi_rid, m_axi_rresp,
                     m_axi_acaddr[OB+BB-1:0], maddr_q[BB-1:0]};
endmodule
